// File: rtl/adsr_envelope_controller_if.sv
// adsr_envelope_controller_if: control, sample and envelope signals of the ADSR/VCA stage.
// Ports: enable, gate, four 8-bit rate/level controls and wave_in flow toward the controller.
//        env_out, wave_out, state_out and busy flow back from it.
interface adsr_envelope_controller_if;
  logic       enable;
  logic       gate;
  logic [7:0] attack_rate;
  logic [7:0] decay_rate;
  logic [7:0] sustain_level;
  logic [7:0] release_rate;
  logic [7:0] wave_in;
  logic [7:0] env_out;
  logic [7:0] wave_out;
  logic [2:0] state_out;
  logic       busy;

  // Driver side (synth control logic / bench).
  modport master (
    output enable, gate, attack_rate, decay_rate, sustain_level, release_rate, wave_in,
    input  env_out, wave_out, state_out, busy
  );

  // Envelope controller side.
  modport slave (
    input  enable, gate, attack_rate, decay_rate, sustain_level, release_rate, wave_in,
    output env_out, wave_out, state_out, busy
  );
endinterface

// File: rtl/adsr_envelope_controller.sv
// adsr_envelope_controller: gate-driven ADSR envelope sequencer plus VCA scaling about midscale.
// Ports: clk, rst (async, active-high); bus (slave modport) carries enable/gate/rates/wave_in in
//        and env_out/wave_out (registered, 1-cycle latency)/state_out/busy out.
module adsr_envelope_controller #(
  parameter int LEVEL_MAX = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  adsr_envelope_controller_if.slave   bus
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ATTACK  = 3'd1;
  localparam logic [2:0] DECAY   = 3'd2;
  localparam logic [2:0] SUSTAIN = 3'd3;
  localparam logic [2:0] RELEASE = 3'd4;

  localparam logic [7:0] LMAX = LEVEL_MAX[7:0];

  logic [2:0] state;
  logic [7:0] cnt;
  logic [7:0] level;
  logic       gate_d;
  logic [7:0] wave_q;

  logic rise;
  logic fall;
  logic held;  // a stage that a gate fall should send to RELEASE

  assign rise = bus.gate & ~gate_d;
  assign fall = ~bus.gate & gate_d;
  assign held = (state == ATTACK) || (state == DECAY) || (state == SUSTAIN);

  // VCA: signed sample times (level+1), arithmetic shift by 8. Gain of 256 at full level
  // gives an exact pass-through; the low byte plus 128 re-centres without saturation.
  logic signed [9:0]  samp;
  logic signed [9:0]  gain;
  logic signed [19:0] prod;
  logic signed [19:0] scaled;
  logic [7:0]         wave_next;

  assign samp      = $signed({2'b00, bus.wave_in}) - 10'sd128;
  assign gain      = $signed({2'b00, level}) + 10'sd1;
  assign prod      = samp * gain;
  assign scaled    = prod >>> 8;
  assign wave_next = scaled[7:0] + 8'd128;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 8'd0;
      level  <= 8'd0;
      gate_d <= 1'b0;
      wave_q <= 8'd128;
    end else begin
      wave_q <= wave_next;
      if (bus.enable) begin
        // gate history only advances while enabled so edges seen while frozen are not lost
        gate_d <= bus.gate;
        if (rise) begin
          state <= ATTACK;
          cnt   <= bus.attack_rate;
        end else if (fall && held) begin
          state <= RELEASE;
          cnt   <= bus.release_rate;
        end else begin
          case (state)
            ATTACK: begin
              if (level == LMAX) begin
                state <= DECAY;
                cnt   <= bus.decay_rate;
              end else if (cnt == 8'd0) begin
                level <= level + 8'd1;
                if (level == LMAX - 8'd1) begin
                  state <= DECAY;
                  cnt   <= bus.decay_rate;
                end else begin
                  cnt <= bus.attack_rate;
                end
              end else begin
                cnt <= cnt - 8'd1;
              end
            end
            DECAY: begin
              if (level <= bus.sustain_level) begin
                state <= SUSTAIN;
              end else if (cnt == 8'd0) begin
                level <= level - 8'd1;
                cnt   <= bus.decay_rate;
              end else begin
                cnt <= cnt - 8'd1;
              end
            end
            RELEASE: begin
              if (level == 8'd0) begin
                state <= IDLE;
              end else if (cnt == 8'd0) begin
                level <= level - 8'd1;
                cnt   <= bus.release_rate;
              end else begin
                cnt <= cnt - 8'd1;
              end
            end
            default: begin
              // IDLE and SUSTAIN hold level
            end
          endcase
        end
      end
    end
  end

  assign bus.env_out   = level;
  assign bus.wave_out  = wave_q;
  assign bus.state_out = state;
  assign bus.busy      = (state != IDLE);

endmodule
